fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: Width, 32, datapath/address width of PC and instruction memory address.
REQ-002 Parameter: ResetPC, 32'h0000_0000, first fetch address after reset (word aligned).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  Width  fetch address, valid while imem_req=1.
REQ-007 imem_gnt  input  1  memory accepts request this cycle when imem_req=1.
REQ-008 imem_rvalid  input  1  response data valid, earliest one cycle after grant.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-011 redirect_pc  input  Width  new fetch address; bits [1:0] ignored (treated as 0).
REQ-012 out_valid  output  1  instruction available to decode.
REQ-013 out_ready  input  1  decode consumes instruction when out_valid=1.
REQ-014 out_instr  output  32  instruction at FIFO head.
REQ-015 out_pc  output  Width  address of out_instr.
REQ-016 out_pcp4  output  Width  out_pc+4, modulo 2^Width.

Function
REQ-017 Block SHALL hold fetch_pc register, 2-entry FIFO of {instr, pc}, and 3-state FSM: IDLE, WAIT, DROP.
REQ-018 At most one request SHALL be outstanding (granted, no response yet).
REQ-019 imem_req SHALL be 1 iff state=IDLE, FIFO count<2, rst=0 and redirect=0; imem_addr SHALL equal fetch_pc.
REQ-020 imem_req&imem_gnt SHALL latch req_pc=fetch_pc, set fetch_pc<=fetch_pc+4 (wrap 0xFFFF_FFFC->0), state<=WAIT.
REQ-021 imem_req=1 without gnt SHALL hold imem_req and imem_addr unchanged next cycle.
REQ-022 WAIT & imem_rvalid SHALL push {imem_rdata, req_pc} into FIFO, state<=IDLE; next request no earlier than following cycle.
REQ-023 Pushed entry SHALL appear at out_* the cycle after imem_rvalid if FIFO was empty (registered, no bypass).
REQ-024 out_valid&out_ready SHALL pop the head; push and pop same cycle SHALL keep count and preserve order.
REQ-025 out_instr/out_pc/out_pcp4 SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 redirect SHALL flush FIFO (out_valid=0 next cycle), set fetch_pc<=redirect_pc&~3, override any same-cycle push or pop.
REQ-027 redirect in WAIT without imem_rvalid SHALL move to DROP; with imem_rvalid SHALL discard data, go IDLE.
REQ-028 DROP & imem_rvalid SHALL discard data, state<=IDLE; redirect in DROP SHALL update fetch_pc, remain DROP.
REQ-029 redirect in IDLE SHALL stay IDLE; first request after redirect at redirect_pc in following cycle.
REQ-030 imem_rvalid in IDLE SHALL be ignored (protocol error, no FIFO change).

Reset
REQ-031 rst=1 SHALL set state=IDLE, fetch_pc=ResetPC, FIFO count=0, out_valid=0, imem_req=0; rst overrides redirect.
REQ-032 rst mid-request SHALL abandon outstanding response; an imem_rvalid after reset in IDLE is ignored per REQ-030.
REQ-033 First imem_req SHALL assert in the first cycle with rst=0, addr=ResetPC.

Verification
REQ-034 Reset release, gnt=1 always, rvalid one cycle after gnt, out_ready=1 -> out_pc sequence 0,4,8,C; out_pcp4=out_pc+4.
REQ-035 out_ready=0 for 6 cycles -> two entries stored, imem_req=0 while count=2, out_* stable; release -> pcs 0,4 in order.
REQ-036 Redirect to 0x100 while WAIT for pc 0x8 -> DROP, 0x8 response discarded, next out_pc=0x100.
REQ-037 Redirect to 0x203 same cycle as imem_rvalid -> data dropped, next imem_addr=0x200, FIFO empty.
REQ-038 ResetPC=0xFFFF_FFFC -> out_pcp4=0, next fetch addr=0x0.
REQ-039 imem_gnt withheld 3 cycles -> imem_req and imem_addr=ResetPC held constant until grant.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Keeps a fetch PC, issues one instruction-memory request at a time and
//   buffers returned words in a 2-entry FIFO of {instr, pc} for decode.
//   A redirect flushes the FIFO and restarts fetch at the new (word aligned)
//   address. A response that is still outstanding when a redirect arrives is
//   discarded via the DROP state.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/imem_addr        fetch request and its address (out)
//   imem_gnt                  memory accepted the request this cycle
//   imem_rvalid/imem_rdata    response strobe and instruction word
//   redirect/redirect_pc      restart fetch at redirect_pc (bits [1:0] ignored)
//   out_valid/out_ready       decode handshake
//   out_instr/out_pc/out_pcp4 FIFO head word, its address, address + 4
module fetch_unit #(
  parameter int unsigned      Width   = 32,
  parameter logic [Width-1:0] ResetPC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [Width-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [Width-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [Width-1:0] out_pc,
  output logic [Width-1:0] out_pcp4
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [Width-1:0] fetch_pc_q, fetch_pc_d;
  logic [Width-1:0] req_pc_q, req_pc_d;

  // FIFO storage; the head is at rd_q, the tail at rd_q + cnt_q.
  logic [31:0]      instr_q [2];
  logic [Width-1:0] pc_q    [2];
  logic             rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop, flush;
  logic             wr_idx;

  assign wr_idx    = rd_q ^ cnt_q[0];
  assign out_valid = (cnt_q != 2'd0);
  assign out_instr = instr_q[rd_q];
  assign out_pc    = pc_q[rd_q];
  assign out_pcp4  = pc_q[rd_q] + Width'(4);
  assign imem_addr = fetch_pc_q;
  // Requests only from IDLE, so a response never arrives into a full FIFO.
  assign imem_req  = (state_q == StIdle) && (cnt_q != 2'd2) && !rst && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    pop        = out_valid && out_ready;
    flush      = 1'b0;

    case (state_q)
      StIdle: begin
        if (imem_req && imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + Width'(4);
          state_d    = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides push/pop; a response still in flight is dropped.
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~(Width'(3));
      push       = 1'b0;
      pop        = 1'b0;
      flush      = 1'b1;
      if (state_q == StWait && !imem_rvalid) state_d = StDrop;
    end

    if (flush) begin
      cnt_d = 2'd0;
      rd_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      rd_d  = rd_q ^ pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetPC;
      req_pc_q   <= '0;
      cnt_q      <= 2'd0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_q[wr_idx] <= imem_rdata;
      pc_q[wr_idx]    <= req_pc_q;
    end
  end

endmodule
